// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, reads instruction memory combinationally and buffers
// {pc, inst} pairs in a 2-entry FIFO drained by decode through a valid/ready handshake.
module instr_fetch_unit #(
   parameter int          ADDR_W   = 6,
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
   input  logic              clk,
   input  logic              rst_n,
   output logic [ADDR_W-1:0] imem_addr,
   input  logic [31:0]       imem_data,
   input  logic              redirect_valid,
   input  logic [31:0]       redirect_pc,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       out_inst,
   output logic [31:0]       out_pc,
   output logic              fetch_err
);

   localparam logic [0:0] STATE_RUN  = 1'b0;
   localparam logic [0:0] STATE_HALT = 1'b1;

   logic [31:0] pc;
   logic [0:0]  state;
   logic [1:0]  count;
   logic [31:0] q_pc   [2];
   logic [31:0] q_inst [2];

   logic pop;
   logic push;
   logic redirect_taken;
   logic tail_idx;

   assign imem_addr      = pc[ADDR_W+1:2];
   assign out_valid      = (count != 2'd0);
   assign out_inst       = out_valid ? q_inst[0] : NOP_INST;
   assign out_pc         = q_pc[0];
   assign pop            = out_valid && out_ready;
   assign redirect_taken = (state == STATE_RUN) && redirect_valid;
   assign push           = (state == STATE_RUN) && !redirect_valid && ((count != 2'd2) || pop);

   // Entry 0 is always the head; a pop shifts entry 1 down, so the write slot
   // is the occupancy left after this cycle's pop.
   assign tail_idx = pop ? (count == 2'd2) : (count == 2'd1);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc        <= RESET_PC;
         state     <= STATE_RUN;
         count     <= 2'd0;
         fetch_err <= 1'b0;
         q_pc[0]   <= 32'd0;
         q_pc[1]   <= 32'd0;
         q_inst[0] <= NOP_INST;
         q_inst[1] <= NOP_INST;
      end else if (redirect_taken) begin
         count <= 2'd0;
         if (redirect_pc[1:0] == 2'b00) begin
            pc <= redirect_pc;
         end else begin
            state     <= STATE_HALT;
            fetch_err <= 1'b1;
         end
      end else begin
         if (pop) begin
            q_pc[0]   <= q_pc[1];
            q_inst[0] <= q_inst[1];
         end
         // Placed after the shift so a push into slot 0 wins over the shifted value.
         if (push) begin
            q_pc[tail_idx]   <= pc;
            q_inst[tail_idx] <= imem_data;
            pc               <= pc + 32'd4;
         end
         count <= count + {1'b0, push} - {1'b0, pop};
      end
   end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Fetch stage that sits directly upstream of the instruction memory. It owns the PC, drives the word address into the instruction memory, and captures the 32-bit word the memory returns combinationally.
- Each fetched {pc, inst} pair goes into a 2-entry prefetch queue. Decode drains the queue through a valid/ready handshake.
- Accepts branch/jump redirects from execute: a redirect flushes the queue and reloads the PC.

Parameters:
- ADDR_W, 6, instruction-memory word-address width (64 words).
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INST, 32'h0000_0013, value driven on out_inst when the queue is empty.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_addr  out  ADDR_W  word address to instruction memory; equals pc[ADDR_W+1:2].
- imem_data  in  32  instruction word from memory, valid in the same cycle as imem_addr.
- redirect_valid  in  1  one-cycle request to load redirect_pc.
- redirect_pc  in  32  redirect target byte address.
- out_valid  out  1  queue head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_inst  out  32  instruction at queue head.
- out_pc  out  32  byte PC of out_inst.
- fetch_err  out  1  sticky misaligned-redirect error.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. All state updates on the rising edge of clk; rst_n assertion takes effect immediately.
- Reset values:
  - pc = RESET_PC, count = 0, state = RUN.
  - out_valid = 0, out_inst = NOP_INST, out_pc = 0, fetch_err = 0.
  - Both queue entries cleared to {0, NOP_INST}.
- imem_addr is combinational from pc. pc[1:0] is always 00. Bits above ADDR_W+1 are ignored by memory, so addresses alias modulo 2^(ADDR_W+2).
- Handshake:
  - pop = out_valid & out_ready.
  - push = (state==RUN) & !redirect_valid & (count<2 | pop).
  - On push: store {pc, imem_data} at the tail; pc <= pc + 4, wrapping modulo 2^32.
- Queue:
  - Storage is 2 entries, registered. count ∈ {0, 1, 2}.
  - out_valid = (count != 0).
  - out_inst and out_pc come from the head entry; out_inst = NOP_INST when count == 0.
  - Push and pop in the same cycle are legal at any count: count stays unchanged and order is preserved (FIFO).
  - When count == 2 and there is no pop: no push, and pc holds.
- Latency: the first instruction appears on out_valid in the first cycle after the first post-reset clock edge. Sustained throughput is 1 instruction/cycle while out_ready = 1.
- Redirect (redirect_valid = 1, state RUN):
  - Queue is flushed (count <= 0) and any concurrent pop is discarded; decode must already treat it as squashed.
  - No push occurs that cycle.
  - If redirect_pc[1:0] == 00: pc <= redirect_pc. The target is fetched next cycle and is visible on out_valid one cycle after that.
  - If redirect_pc[1:0] != 00: state <= HALT, fetch_err <= 1, pc unchanged.
- State machine:
  - RUN → HALT only on a misaligned redirect.
  - HALT: no pushes; pops continue to drain (the queue is already empty after the flush); further redirects are ignored.
  - HALT → RUN only via rst_n.
- Reset mid-operation: all state returns to reset values asynchronously, and any in-flight queue contents are lost.

Test Plan:
- Reset, then out_ready=1 with memory words 0,1,2 preloaded → out_pc sequence 0,4,8 on consecutive cycles; out_inst matches the memory words; out_valid first high 1 cycle after reset release.
- out_ready=0 for 5 cycles → count saturates at 2, out_pc holds at 0, pc holds at 8. Then out_ready=1 → 0,4,8,12 delivered with no gap and no duplicate.
- redirect_valid with redirect_pc=32'h10 while the queue is full → next cycle out_valid=0; one cycle later out_pc=32'h10, out_inst=mem[4].
- PC wrap: redirect to 32'hFC, out_ready=1 → out_pc 32'hFC (imem_addr 63), then 32'h100 with imem_addr 0 (alias of word 0).
- redirect_pc=32'h6 → fetch_err=1 next cycle, out_valid stays 0 indefinitely, and a later aligned redirect is ignored. Asserting rst_n=0 clears fetch_err immediately.
- rst_n asserted asynchronously mid-stream with count=2 → out_valid=0 and out_inst=NOP_INST before the next edge; fetch restarts at RESET_PC.
